// File: rtl/store_queue.sv
`default_nettype none
// ============================================================================
// Module   : store_queue
// Function : In-order store queue. Allocates up to two stores per cycle,
//            captures address and data from the store FU, marks stores
//            retired from the ROB count, and drains retired stores to the
//            D-cache one at a time over a req/ack handshake. On a branch
//            mispredict the tail is restored from a branch-stack snapshot.
// Revision : 1.0 - initial release
// ============================================================================
module store_queue #(
   parameter int SQ_DEPTH = 8,
   parameter int PTR_W    = 3,
   parameter int ADDR_W   = 64,
   parameter int DATA_W   = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        disp_n,
   output logic [PTR_W:0]    sq_tail,
   output logic [PTR_W:0]    sq_available,
   output logic              sq_empty,
   input  logic              exec_valid,
   input  logic [PTR_W-1:0]  exec_idx,
   input  logic [ADDR_W-1:0] exec_addr,
   input  logic [DATA_W-1:0] exec_data,
   input  logic [1:0]        rob_nRetireStores,
   input  logic              br_pred_wrong,
   input  logic [PTR_W:0]    bs_recov_sq_tail,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data,
   input  logic              mem_ack
);

   localparam int PW = PTR_W + 1;

   // Pointers carry one wrap bit above the index bits.
   logic [PW-1:0]       head;
   logic [PW-1:0]       ret_ptr;
   logic [PW-1:0]       tail;
   logic [PW-1:0]       avail;

   // Per-entry state.
   logic [SQ_DEPTH-1:0] valid;
   logic [SQ_DEPTH-1:0] ready;
   logic [SQ_DEPTH-1:0] retired;
   logic [ADDR_W-1:0]   addr_q [SQ_DEPTH];
   logic [DATA_W-1:0]   data_q [SQ_DEPTH];

   // Per-entry event masks for this cycle.
   logic [SQ_DEPTH-1:0] disp_hit;
   logic [SQ_DEPTH-1:0] retire_hit;
   logic [SQ_DEPTH-1:0] squash_hit;
   logic [SQ_DEPTH-1:0] exec_hit;

   logic [PTR_W-1:0]    head_idx;
   logic [PW-1:0]       squash_span;
   logic [PW-1:0]       next_head;
   logic [PW-1:0]       next_tail;
   logic                drain;

   assign head_idx     = head[PTR_W-1:0];
   assign mem_req      = !reset && valid[head_idx] && retired[head_idx];
   assign mem_addr     = reset ? '0 : addr_q[head_idx];
   assign mem_data     = reset ? '0 : data_q[head_idx];
   assign drain        = mem_req && mem_ack;
   assign sq_tail      = tail;
   assign sq_available = avail;
   assign sq_empty     = (head == tail);

   // Squashed span is [recovery tail, current tail); its length is the modular distance.
   assign squash_span  = tail - bs_recov_sq_tail;
   assign next_head    = head + (drain ? PW'(1) : PW'(0));
   assign next_tail    = br_pred_wrong ? bs_recov_sq_tail : (tail + PW'(disp_n));

   // Classify every entry by its modular distance from the relevant pointer.
   always_comb begin
      disp_hit   = '0;
      retire_hit = '0;
      squash_hit = '0;
      exec_hit   = '0;
      for (int i = 0; i < SQ_DEPTH; i++) begin
         disp_hit[i]   = !br_pred_wrong &&
                         ({1'b0, PTR_W'(i) - tail[PTR_W-1:0]} < PW'(disp_n));
         retire_hit[i] = ({1'b0, PTR_W'(i) - ret_ptr[PTR_W-1:0]} < PW'(rob_nRetireStores));
         squash_hit[i] = br_pred_wrong &&
                         ({1'b0, PTR_W'(i) - bs_recov_sq_tail[PTR_W-1:0]} < squash_span);
         exec_hit[i]   = exec_valid && valid[i] && (exec_idx == PTR_W'(i)) && !squash_hit[i];
      end
   end

   // Pointer and free-count update; free count reflects post-recovery, post-drain pointers.
   always_ff @(posedge clk) begin
      if (reset) begin
         head    <= '0;
         ret_ptr <= '0;
         tail    <= '0;
         avail   <= PW'(SQ_DEPTH);
      end else begin
         head    <= next_head;
         ret_ptr <= ret_ptr + PW'(rob_nRetireStores);
         tail    <= next_tail;
         avail   <= PW'(SQ_DEPTH) - (next_tail - next_head);
      end
   end

   // Entry state update: drain clears the head; otherwise allocate, capture, retire, squash.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid   <= '0;
         ready   <= '0;
         retired <= '0;
         for (int i = 0; i < SQ_DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < SQ_DEPTH; i++) begin
            if (drain && (head_idx == PTR_W'(i))) begin
               valid[i]   <= 1'b0;
               ready[i]   <= 1'b0;
               retired[i] <= 1'b0;
            end else if (squash_hit[i]) begin
               valid[i]   <= 1'b0;
               ready[i]   <= 1'b0;
               retired[i] <= 1'b0;
            end else begin
               if (disp_hit[i]) begin
                  valid[i]   <= 1'b1;
                  ready[i]   <= 1'b0;
                  retired[i] <= 1'b0;
               end
               if (exec_hit[i]) begin
                  ready[i]  <= 1'b1;
                  addr_q[i] <= exec_addr;
                  data_q[i] <= exec_data;
               end
               if (retire_hit[i]) begin
                  retired[i] <= 1'b1;
               end
            end
         end
      end
   end

   // The ROB may only retire stores whose address and data are already captured.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < SQ_DEPTH; i++) begin
            if (retire_hit[i]) begin
               assert (valid[i] && ready[i]);
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_store_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_queue
// Function : Directed self-checking bench for store_queue with a queue-level
//            reference model compared against the DUT every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_store_queue;

   localparam int D = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  disp_n;
   logic [3:0]  sq_tail;
   logic [3:0]  sq_available;
   logic        sq_empty;
   logic        exec_valid;
   logic [2:0]  exec_idx;
   logic [63:0] exec_addr;
   logic [63:0] exec_data;
   logic [1:0]  rob_nRetireStores;
   logic        br_pred_wrong;
   logic [3:0]  bs_recov_sq_tail;
   logic        mem_req;
   logic [63:0] mem_addr;
   logic [63:0] mem_data;
   logic        mem_ack;

   int n_chk  = 0;
   int n_fail = 0;

   store_queue #(.SQ_DEPTH(8), .PTR_W(3), .ADDR_W(64), .DATA_W(64)) dut (
      .clk(clk), .reset(reset), .disp_n(disp_n), .sq_tail(sq_tail),
      .sq_available(sq_available), .sq_empty(sq_empty),
      .exec_valid(exec_valid), .exec_idx(exec_idx), .exec_addr(exec_addr),
      .exec_data(exec_data), .rob_nRetireStores(rob_nRetireStores),
      .br_pred_wrong(br_pred_wrong), .bs_recov_sq_tail(bs_recov_sq_tail),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model: unbounded integer pointers ----------------
   int          m_head, m_ret, m_tail;
   bit          m_valid [D];
   bit          m_ready [D];
   bit          m_retd  [D];
   logic [63:0] m_addr  [D];
   logic [63:0] m_data  [D];
   bit          started = 0;

   function automatic bit m_req();
      return m_valid[m_head % D] && m_retd[m_head % D];
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_head = 0; m_ret = 0; m_tail = 0;
         for (int i = 0; i < D; i++) begin
            m_valid[i] = 0; m_ready[i] = 0; m_retd[i] = 0;
            m_addr[i] = '0; m_data[i] = '0;
         end
         started = 1;
      end else if (started) begin
         bit do_drain;
         bit squashed [D];
         int new_tail;
         do_drain = m_req() && mem_ack;
         for (int i = 0; i < D; i++) squashed[i] = 0;
         new_tail = m_tail;
         if (br_pred_wrong) begin
            new_tail = m_tail - ((m_tail - int'(bs_recov_sq_tail)) & 15);
            for (int p = new_tail; p < m_tail; p++) squashed[p % D] = 1;
         end
         if (exec_valid && m_valid[exec_idx] && !squashed[exec_idx]) begin
            m_ready[exec_idx] = 1;
            m_addr[exec_idx]  = exec_addr;
            m_data[exec_idx]  = exec_data;
         end
         for (int k = 0; k < int'(rob_nRetireStores); k++) begin
            chk("retire_legal", {63'd0, m_valid[(m_ret + k) % D] && m_ready[(m_ret + k) % D]}, 64'd1);
            m_retd[(m_ret + k) % D] = 1;
         end
         m_ret += int'(rob_nRetireStores);
         if (br_pred_wrong) begin
            for (int i = 0; i < D; i++)
               if (squashed[i]) begin m_valid[i] = 0; m_ready[i] = 0; m_retd[i] = 0; end
            m_tail = new_tail;
         end else begin
            for (int k = 0; k < int'(disp_n); k++) begin
               m_valid[(m_tail + k) % D] = 1;
               m_ready[(m_tail + k) % D] = 0;
               m_retd[(m_tail + k) % D]  = 0;
            end
            m_tail += int'(disp_n);
         end
         if (do_drain) begin
            m_valid[m_head % D] = 0; m_ready[m_head % D] = 0; m_retd[m_head % D] = 0;
            m_head++;
         end
      end
   end

   // Compare process: every cycle outside reset, away from the active edge.
   always @(negedge clk) begin
      if (started && !reset) begin
         chk("cyc_tail",  {60'd0, sq_tail}, 64'(m_tail % 16));
         chk("cyc_avail", {60'd0, sq_available}, 64'(D - (m_tail - m_head)));
         chk("cyc_empty", {63'd0, sq_empty}, {63'd0, m_tail == m_head});
         chk("cyc_req",   {63'd0, mem_req}, {63'd0, m_req()});
         if (m_req()) begin
            chk("cyc_addr", mem_addr, m_addr[m_head % D]);
            chk("cyc_data", mem_data, m_data[m_head % D]);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
      disp_n = 0; exec_valid = 0; rob_nRetireStores = 0;
      br_pred_wrong = 0; mem_ack = 0;
   endtask

   task automatic do_reset();
      reset = 1; tick(); tick(); reset = 0;
   endtask

   task automatic exec(input logic [2:0] idx, input logic [63:0] a, input logic [63:0] d);
      exec_valid = 1; exec_idx = idx; exec_addr = a; exec_data = d; tick();
   endtask

   initial begin
      reset = 1; disp_n = 0; exec_valid = 0; exec_idx = 0; exec_addr = 0; exec_data = 0;
      rob_nRetireStores = 0; br_pred_wrong = 0; bs_recov_sq_tail = 0; mem_ack = 0;

      // 1: basic allocate / execute / retire / drain
      do_reset();
      chk("rst_avail", {60'd0, sq_available}, 64'd8);
      chk("rst_empty", {63'd0, sq_empty}, 64'd1);
      chk("rst_req",   {63'd0, mem_req}, 64'd0);
      chk("rst_tail",  {60'd0, sq_tail}, 64'd0);
      chk("rst_addr",  mem_addr, 64'd0);
      disp_n = 2; tick();
      chk("t1_avail6", {60'd0, sq_available}, 64'd6);
      exec(3'd0, 64'hA000, 64'hD000);
      exec(3'd1, 64'hA001, 64'hD001);
      rob_nRetireStores = 2; tick();
      chk("t1_req",   {63'd0, mem_req}, 64'd1);
      chk("t1_addr0", mem_addr, 64'hA000);
      mem_ack = 1; tick();
      chk("t1_addr1", mem_addr, 64'hA001);
      chk("t1_data1", mem_data, 64'hD001);
      mem_ack = 1; tick();
      chk("t1_avail8", {60'd0, sq_available}, 64'd8);
      chk("t1_empty",  {63'd0, sq_empty}, 64'd1);

      // 2: fill, tail wraps with wrap bit set, drain frees one slot
      do_reset();
      for (int c = 0; c < 4; c++) begin disp_n = 2; tick(); end
      chk("t2_full",  {60'd0, sq_available}, 64'd0);
      chk("t2_tail",  {60'd0, sq_tail}, 64'h8);
      exec(3'd0, 64'hB000, 64'hE000);
      rob_nRetireStores = 1; tick();
      mem_ack = 1; tick();
      chk("t2_avail1", {60'd0, sq_available}, 64'd1);

      // 3: head held while ack low
      exec(3'd1, 64'hB001, 64'hE001);
      rob_nRetireStores = 1; tick();
      for (int c = 0; c < 5; c++) begin
         chk("t3_hold_req",  {63'd0, mem_req}, 64'd1);
         chk("t3_hold_addr", mem_addr, 64'hB001);
         chk("t3_hold_data", mem_data, 64'hE001);
         tick();
      end
      mem_ack = 1; tick();
      chk("t3_avail2", {60'd0, sq_available}, 64'd2);
      chk("t3_req0",   {63'd0, mem_req}, 64'd0);

      // 4: mispredict with same-cycle dispatch
      do_reset();
      disp_n = 2; tick(); disp_n = 2; tick(); disp_n = 1; tick();
      chk("t4_tail5", {60'd0, sq_tail}, 64'd5);
      br_pred_wrong = 1; bs_recov_sq_tail = 4'd2; disp_n = 2; tick();
      chk("t4_tail2",  {60'd0, sq_tail}, 64'd2);
      chk("t4_avail6", {60'd0, sq_available}, 64'd6);

      // 5: drain and recovery in the same cycle
      do_reset();
      disp_n = 2; tick(); disp_n = 2; tick();
      exec(3'd0, 64'hC000, 64'hF000);
      rob_nRetireStores = 1; tick();
      mem_ack = 1; br_pred_wrong = 1; bs_recov_sq_tail = 4'd2; tick();
      chk("t5_tail",  {60'd0, sq_tail}, 64'd2);
      chk("t5_avail", {60'd0, sq_available}, 64'd7);
      chk("t5_req",   {63'd0, mem_req}, 64'd0);

      // 6: exec to an entry squashed that cycle, then reallocation
      disp_n = 2; tick();
      exec_valid = 1; exec_idx = 3'd2; exec_addr = 64'hDEAD; exec_data = 64'hBEEF;
      br_pred_wrong = 1; bs_recov_sq_tail = 4'd2; tick();
      disp_n = 1; tick();
      exec(3'd1, 64'hC001, 64'hF001);
      exec(3'd2, 64'hC002, 64'hF002);
      rob_nRetireStores = 2; tick();
      chk("t6_addr1", mem_addr, 64'hC001);
      mem_ack = 1; tick();
      chk("t6_addr2", mem_addr, 64'hC002);
      chk("t6_data2", mem_data, 64'hF002);
      mem_ack = 1; tick();
      chk("t6_empty", {63'd0, sq_empty}, 64'd1);

      // reset while a drain is pending: request drops in the reset cycle
      disp_n = 1; tick();
      exec(3'd3, 64'hC003, 64'hF003);
      rob_nRetireStores = 1; tick();
      chk("rm_req1", {63'd0, mem_req}, 64'd1);
      reset = 1; #1;
      chk("rm_req0", {63'd0, mem_req}, 64'd0);
      tick(); reset = 0;
      chk("rm_avail", {60'd0, sq_available}, 64'd8);
      chk("rm_empty", {63'd0, sq_empty}, 64'd1);
      tick(); tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1);
   end

endmodule
`default_nettype wire
